// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared state encodings and divider handshake constants
package div_issue_ctrl_pkg;
  typedef enum logic [1:0] {
    DivCtrlIdle  = 2'd0,
    DivCtrlBusy  = 2'd1,
    DivCtrlDone  = 2'd2,
    DivCtrlDrain = 2'd3
  } div_ctrl_e;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;
endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage issue, stall and result capture for the multi-cycle divider
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        ex_div_i,
  input  logic        ex_divu_i,
  input  logic [31:0] ex_op1_i,
  input  logic [31:0] ex_op2_i,
  input  logic        flush_i,
  input  logic        mem_stall_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_req_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  div_ctrl_e state_q, state_d;
  logic [CW-1:0] drain_q;
  logic [31:0] op1_q, op2_q;
  logic signed_q;
  logic issue;
  logic take_result;
  // rst gates issue so every output reads 0 while reset is held, even with a DIV sitting in EX
  assign issue = (state_q == DivCtrlIdle) & ex_valid_i & (ex_div_i | ex_divu_i) & ~flush_i & ~rst;
  assign take_result = (state_q == DivCtrlBusy) & ~flush_i & (div_ready_i == DivResultReady);
  // the issue cycle forwards EX operands directly, afterwards the latched copies are held stable
  assign div_op1_o = issue ? ex_op1_i : op1_q;
  assign div_op2_o = issue ? ex_op2_i : op2_q;
  assign div_signed_o = issue ? ex_div_i : signed_q;
  assign busy_o = state_q != DivCtrlIdle;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DivCtrlIdle;
    else state_q <= state_d;
  end
  // next state and handshake outputs
  always_comb begin
    state_d = state_q;
    div_start_o = DivStop;
    div_annul_o = 1'b0;
    stall_req_o = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      DivCtrlIdle: begin
        div_start_o = issue ? DivStart : DivStop;
        stall_req_o = issue;
        state_d = issue ? DivCtrlBusy : DivCtrlIdle;
      end
      DivCtrlBusy: begin
        stall_req_o = 1'b1;
        div_start_o = flush_i ? DivStop : DivStart;
        div_annul_o = flush_i;
        state_d = flush_i ? DivCtrlDrain : (take_result ? DivCtrlDone : DivCtrlBusy);
      end
      DivCtrlDone: begin
        result_valid_o = ~flush_i;
        state_d = (~mem_stall_i | flush_i) ? DivCtrlIdle : DivCtrlDone;
      end
      default: begin
        div_annul_o = 1'b1;
        state_d = (drain_q == '0) ? DivCtrlIdle : DivCtrlDrain;
      end
    endcase
  end
  // operand latches captured at issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q <= ZeroWord;
      op2_q <= ZeroWord;
      signed_q <= 1'b0;
    end else if (issue) begin
      op1_q <= ex_op1_i;
      op2_q <= ex_op2_i;
      signed_q <= ex_div_i;
    end
  end
  // result capture: remainder to hi, quotient to lo
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= ZeroWord;
      lo_o <= ZeroWord;
    end else if (take_result) begin
      hi_o <= div_result_i[63:32];
      lo_o <= div_result_i[31:0];
    end
  end
  // drain counter keeps start low long enough for the divider to return to free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drain_q <= '0;
    else if (state_q == DivCtrlBusy && flush_i) drain_q <= CW'(DRAIN_CYCLES - 1);
    else if (state_q == DivCtrlDrain && drain_q != '0) drain_q <= drain_q - CW'(1);
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed table-driven bench with a behavioural divider beside the DUT
module tb_div_issue_ctrl;
  logic clk, rst;
  logic ex_valid_i, ex_div_i, ex_divu_i, flush_i, mem_stall_i, div_ready_i;
  logic [31:0] ex_op1_i, ex_op2_i;
  logic [63:0] div_result_i;
  logic div_start_o, div_annul_o, div_signed_o, stall_req_o, result_valid_o, busy_o;
  logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic div;
    logic divu;
    logic sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int n;
  } vec_t;
  vec_t vt[9];

  div_issue_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_div_i(ex_div_i), .ex_divu_i(ex_divu_i),
    .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i), .flush_i(flush_i), .mem_stall_i(mem_stall_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i), .div_start_o(div_start_o),
    .div_annul_o(div_annul_o), .div_signed_o(div_signed_o), .div_op1_o(div_op1_o),
    .div_op2_o(div_op2_o), .stall_req_o(stall_req_o), .result_valid_o(result_valid_o),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // behavioural divider: free(0) / computing(1) / result held(2)
  logic [1:0] m_st;
  logic [5:0] m_cnt;
  logic [31:0] m_a, m_b;
  logic m_s;
  logic signed [31:0] sa, sb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_a <= 0; m_b <= 0; m_s <= 0;
    end else begin
      case (m_st)
        2'd0: if (div_start_o) begin
          m_a <= div_op1_o; m_b <= div_op2_o; m_s <= div_signed_o;
          m_cnt <= (div_op2_o == 0) ? 6'd0 : 6'd32;
          m_st <= 2'd1;
        end
        2'd1: if (div_annul_o) m_st <= 2'd0;
              else if (m_cnt == 0) m_st <= 2'd2;
              else m_cnt <= m_cnt - 6'd1;
        default: if (!div_start_o) m_st <= 2'd0;
      endcase
    end
  end
  assign div_ready_i = (m_st == 2'd2);
  always_comb begin
    sa = m_a;
    sb = m_b;
    div_result_i = 64'h0;
    if (m_b != 0) div_result_i = m_s ? {32'(sa % sb), 32'(sa / sb)} : {m_a % m_b, m_a / m_b};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_div(input vec_t v);
    ex_valid_i = 1; ex_div_i = v.div; ex_divu_i = v.divu; ex_op1_i = v.a; ex_op2_i = v.b;
    #1;
    chk("issue_start", div_start_o, 1);
    chk("issue_stall", stall_req_o, 1);
    chk("issue_signed", div_signed_o, v.sgn);
    step();
    ex_valid_i = 0; ex_div_i = 0; ex_divu_i = 0; ex_op1_i = 32'hDEADBEEF; ex_op2_i = 32'h5A5A5A5A;
    #1;
  endtask

  task automatic finish_div(input vec_t v, input int hold);
    int n = 1;
    bit done = 0, ops_ok = 1, stall_ok = 1;
    for (int i = 0; i < 100; i++) begin
      if (result_valid_o) begin
        done = 1;
        break;
      end
      n += int'(div_start_o);
      if (div_op1_o !== v.a || div_op2_o !== v.b || div_signed_o !== v.sgn) ops_ok = 0;
      if (!stall_req_o) stall_ok = 0;
      step();
    end
    chk("done_seen", done, 1);
    chk("start_cycles", n, v.n);
    chk("ops_held", ops_ok, 1);
    chk("busy_stall", stall_ok, 1);
    chk("hi", hi_o, v.hi);
    chk("lo", lo_o, v.lo);
    chk("done_start", div_start_o, 0);
    chk("done_stall", stall_req_o, 0);
    for (int i = 1; i < hold; i++) begin
      step();
      chk("hold_valid", result_valid_o, 1);
      chk("hold_hilo", {hi_o, lo_o}, {v.hi, v.lo});
      chk("hold_start", div_start_o, 0);
    end
    if (hold > 0) mem_stall_i = 0;
  endtask

  task automatic run_div(input vec_t v);
    issue_div(v);
    finish_div(v, 0);
  endtask

  task automatic drain(output int n, output bit ok);
    n = 0;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      if (!busy_o) break;
      if (!div_annul_o || div_start_o || stall_req_o || result_valid_o) ok = 0;
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    bit ok;
    vt[0] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 35};
    vt[2] = '{1'b1, 1'b0, 1'b1, 32'h1234, 32'd0, 32'h0, 32'h0, 3};
    vt[3] = '{1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 35};
    vt[6] = '{1'b1, 1'b0, 1'b1, 32'd1000, 32'd3, 32'd1, 32'd333, 35};
    vt[7] = '{1'b1, 1'b0, 1'b1, 32'd20, 32'd3, 32'd2, 32'd6, 35};
    vt[8] = '{1'b1, 1'b0, 1'b1, 32'd9, 32'd0, 32'd0, 32'd0, 3};
    rst = 1; ex_valid_i = 0; ex_div_i = 0; ex_divu_i = 0; ex_op1_i = 0; ex_op2_i = 0;
    flush_i = 0; mem_stall_i = 0;
    #1;
    chk("rst_ctrl", {div_start_o, div_annul_o, div_signed_o, stall_req_o, result_valid_o, busy_o}, 0);
    chk("rst_ops", {div_op1_o, div_op2_o}, 0);
    chk("rst_res", {hi_o, lo_o}, 0);
    step();
    rst = 0;
    step();
    // flush in IDLE blocks issue
    ex_valid_i = 1; ex_div_i = 1; flush_i = 1;
    #1;
    chk("flush_idle_start", {div_start_o, stall_req_o}, 0);
    step();
    ex_valid_i = 0; ex_div_i = 0; flush_i = 0;
    #1;
    chk("flush_idle_busy", busy_o, 0);
    // table: each divide issues the cycle after the previous DONE
    for (int i = 0; i < 6; i++) begin
      run_div(vt[i]);
      step();
      chk("idle_after", {busy_o, result_valid_o}, 0);
    end
    // flush at cycle 10 of BUSY, drain, then a fresh DIVU
    issue_div(vt[6]);
    repeat (9) step();
    flush_i = 1;
    #1;
    chk("fl_annul", div_annul_o, 1);
    chk("fl_start", div_start_o, 0);
    chk("fl_valid", result_valid_o, 0);
    step();
    flush_i = 0;
    #1;
    drain(n, ok);
    chk("fl_drain_cycles", n, 3);
    chk("fl_drain_sig", ok, 1);
    run_div(vt[3]);
    step();
    // flush beats a same-cycle ready; result discarded
    issue_div(vt[8]);
    step();
    chk("rf_ready_pre", div_ready_i, 1);
    flush_i = 1;
    #1;
    chk("rf_annul", {div_annul_o, div_start_o, result_valid_o}, 3'b100);
    step();
    flush_i = 0;
    #1;
    drain(n, ok);
    chk("rf_drain_cycles", n, 3);
    chk("rf_drain_sig", ok, 1);
    chk("rf_hilo_kept", {hi_o, lo_o}, {32'd2, 32'd14});
    // downstream stall holds the result for 4 cycles
    mem_stall_i = 1;
    issue_div(vt[6]);
    finish_div(vt[6], 4);
    step();
    chk("stall_idle_after", {busy_o, result_valid_o}, 0);
    // asynchronous reset between edges in BUSY
    issue_div(vt[6]);
    repeat (5) step();
    #2;
    rst = 1;
    #1;
    chk("arst_ctrl", {div_start_o, div_annul_o, div_signed_o, stall_req_o, result_valid_o, busy_o}, 0);
    chk("arst_ops", {div_op1_o, div_op2_o}, 0);
    chk("arst_res", {hi_o, lo_o}, 0);
    step();
    rst = 0;
    step();
    run_div(vt[7]);
    step();
    chk("post_rst_idle", busy_o, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
